interrupt_sequencer: RTL and testbench

Sequences the 7-cycle reset/NMI/IRQ/BRK entry on the internal datapath. It arbitrates the pending interrupt sources at instruction boundaries and steps a cycle counter that the flag decoder uses to drive the PC push, PSR push and vector fetch. It also selects which ADL preset vector (FA/FC/FE) is fetched and suppresses stack writes during reset.

---
 rtl/interrupt_sequencer_pkg.sv | 40 ++++
 rtl/interrupt_sequencer_if.sv | 36 +++
 rtl/interrupt_edge_sync.sv | 30 +++
 rtl/interrupt_sequencer.sv | 127 ++++++++++++
 tb/tb_interrupt_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared constants for the interrupt entry sequencer: vector selects, entry
// sources, FSM states and the step numbers the flag decoder keys on.
package interrupt_sequencer_pkg;

    typedef enum logic [1:0] {
        VEC_NMI   = 2'd0,  // ADL FA
        VEC_RESET = 2'd1,  // ADL FC
        VEC_IRQ   = 2'd2   // ADL FE, shared by IRQ and BRK
    } vec_sel_e;

    typedef enum logic [1:0] {
        SRC_RESET = 2'd0,
        SRC_NMI   = 2'd1,
        SRC_IRQ   = 2'd2,
        SRC_BRK   = 2'd3
    } seq_src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } seq_state_e;

    localparam logic [2:0] STEP_PUSH_PCH = 3'd2;
    localparam logic [2:0] STEP_PUSH_PCL = 3'd3;
    localparam logic [2:0] STEP_PUSH_PSR = 3'd4;
    localparam logic [2:0] STEP_VEC_LOW  = 3'd5;
    localparam logic [2:0] STEP_VEC_HIGH = 3'd6;
    localparam logic [2:0] SEQ_LAST      = 3'd6;

    function automatic vec_sel_e src_vector(input seq_src_e src);
        vec_sel_e v;
        case (src)
            SRC_RESET: v = VEC_RESET;
            SRC_NMI:   v = VEC_NMI;
            default:   v = VEC_IRQ;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Signal bundle between the decoder/flag logic (master) and the interrupt
// sequencer (slave).
interface interrupt_sequencer_if;
    import interrupt_sequencer_pkg::*;

    // No valid/ready pairs here: instrBoundary and brkRequest are sampled
    // every cycle in IDLE; seqStep, vectorSel and the flags are only
    // meaningful while seqActive is high, and the two pulses last one cycle.
    logic       nmi_n;
    logic       irq_n;
    logic       psrIrqMask;
    logic       instrBoundary;
    logic       brkRequest;

    logic       seqActive;
    logic [2:0] seqStep;
    vec_sel_e   vectorSel;
    logic       pushEnable;
    logic       breakFlag;
    logic       setInterruptMask;
    logic       seqDone;
    seq_state_e seqState;

    modport master (
        output nmi_n, irq_n, psrIrqMask, instrBoundary, brkRequest,
        input  seqActive, seqStep, vectorSel, pushEnable, breakFlag,
               setInterruptMask, seqDone, seqState
    );

    modport slave (
        input  nmi_n, irq_n, psrIrqMask, instrBoundary, brkRequest,
        output seqActive, seqStep, vectorSel, pushEnable, breakFlag,
               setInterruptMask, seqDone, seqState
    );

endinterface

// File: rtl/interrupt_edge_sync.sv
// Multi-flop synchronizer for an asynchronous active-low line, with a
// falling-edge pulse derived from the synchronized value.
module interrupt_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    // Flops reset to the inactive (high) level so reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '1;
            prev_q  <= 1'b1;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], async_i};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign fall_o = prev_q & ~chain_q[STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// Arbitrates reset/NMI/IRQ/BRK at instruction boundaries and steps the
// 7-cycle entry sequence, including the late NMI vector hijack.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    interrupt_sequencer_if.slave  bus
);

    logic nmi_fall;
    logic nmi_sync_unused;
    logic irq_sync;
    logic irq_fall_unused;
    logic irq_take;

    seq_state_e state_q, state_d;
    logic [2:0] step_q, step_d;
    seq_src_e   src_q, src_d;
    vec_sel_e   vec_q, vec_d;
    logic       reset_pend_q, reset_pend_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       active;

    interrupt_edge_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk     (clk),
        .rst_n   (nrst),
        .async_i (bus.nmi_n),
        .sync_o  (nmi_sync_unused),
        .fall_o  (nmi_fall)
    );

    interrupt_edge_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk     (clk),
        .rst_n   (nrst),
        .async_i (bus.irq_n),
        .sync_o  (irq_sync),
        .fall_o  (irq_fall_unused)
    );

    assign irq_take = ~irq_sync & ~bus.psrIrqMask;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            step_q       <= 3'd0;
            src_q        <= SRC_RESET;
            vec_q        <= VEC_RESET;
            reset_pend_q <= 1'b1;
            nmi_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            src_q        <= src_d;
            vec_q        <= vec_d;
            reset_pend_q <= reset_pend_d;
            nmi_pend_q   <= nmi_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        src_d        = src_q;
        vec_d        = vec_q;
        reset_pend_d = reset_pend_q;
        nmi_pend_d   = nmi_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.instrBoundary && (reset_pend_q || nmi_pend_q || irq_take)) begin
                    state_d = ST_SEQ;
                    step_d  = 3'd0;
                    if (reset_pend_q)    src_d = SRC_RESET;
                    else if (nmi_pend_q) src_d = SRC_NMI;
                    else                 src_d = SRC_IRQ;
                    vec_d = src_vector(src_d);
                end else if (bus.brkRequest) begin
                    state_d = ST_SEQ;
                    step_d  = 3'd0;
                    src_d   = SRC_BRK;
                    vec_d   = VEC_IRQ;
                end
            end
            ST_SEQ: begin
                if (step_q == SEQ_LAST) begin
                    state_d = ST_IDLE;
                    step_d  = 3'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
                // The vector stays open through step 4; leaving step 4 freezes it.
                if (step_q <= STEP_PUSH_PSR) begin
                    if (nmi_pend_q && (src_q == SRC_IRQ || src_q == SRC_BRK)) begin
                        vec_d = VEC_NMI;
                    end
                    if (step_q == STEP_PUSH_PSR) begin
                        if (vec_d == VEC_NMI)    nmi_pend_d   = 1'b0;
                        if (src_q == SRC_RESET)  reset_pend_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = 3'd0;
            end
        endcase

        // A fresh edge always wins over a same-cycle clear so it is never lost.
        if (nmi_fall) nmi_pend_d = 1'b1;
    end

    assign active = (state_q == ST_SEQ);

    assign bus.seqActive        = active;
    assign bus.seqStep          = step_q;
    assign bus.vectorSel        = vec_q;
    assign bus.pushEnable       = active && (src_q != SRC_RESET) &&
                                  (step_q >= STEP_PUSH_PCH) && (step_q <= STEP_PUSH_PSR);
    assign bus.breakFlag        = active && (src_q == SRC_BRK);
    assign bus.setInterruptMask = active && (step_q == STEP_VEC_LOW);
    assign bus.seqDone          = active && (step_q == STEP_VEC_HIGH);
    assign bus.seqState         = state_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: a cycle model of the entry rules,
// a per-sequence log, and literal expectations for each scenario.
module tb_interrupt_sequencer;
    import interrupt_sequencer_pkg::*;

    localparam int SYNC    = 2;
    localparam int M_RESET = 0;
    localparam int M_NMI   = 1;
    localparam int M_IRQ   = 2;
    localparam int M_BRK   = 3;

    logic clk = 1'b0;
    logic nrst;

    interrupt_sequencer_if bus();

    interrupt_sequencer #(.SYNC_STAGES(SYNC)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic            m_active;
    int              m_cycle;
    int              m_src;
    vec_sel_e        m_vec;
    logic            m_rp;
    logic            m_np;
    logic [SYNC+1:0] nmi_hist;  // bit 0 = sample taken at the latest edge
    logic [SYNC:0]   irq_hist;

    task automatic model_reset();
        m_active = 1'b0;
        m_cycle  = 0;
        m_src    = M_RESET;
        m_vec    = VEC_RESET;
        m_rp     = 1'b1;
        m_np     = 1'b0;
        nmi_hist = '1;
        irq_hist = '1;
    endtask

    task automatic model_step();
        logic irq_ok;
        logic nmi_edge;
        logic go;
        nmi_hist = {nmi_hist[SYNC:0], bus.nmi_n};
        irq_hist = {irq_hist[SYNC-1:0], bus.irq_n};
        irq_ok   = !irq_hist[SYNC] && !bus.psrIrqMask;
        nmi_edge = !nmi_hist[SYNC] && nmi_hist[SYNC+1];
        go = 1'b0;
        if (!m_active) begin
            if (bus.instrBoundary && (m_rp || m_np || irq_ok)) begin
                go = 1'b1;
                if (m_rp)      m_src = M_RESET;
                else if (m_np) m_src = M_NMI;
                else           m_src = M_IRQ;
            end else if (bus.brkRequest) begin
                go = 1'b1;
                m_src = M_BRK;
            end
            if (go) begin
                m_active = 1'b1;
                m_cycle  = 0;
                if (m_src == M_RESET)    m_vec = VEC_RESET;
                else if (m_src == M_NMI) m_vec = VEC_NMI;
                else                     m_vec = VEC_IRQ;
            end
        end else begin
            if (m_cycle <= 4 && m_np && m_src >= M_IRQ) m_vec = VEC_NMI;
            if (m_cycle == 4 && m_vec == VEC_NMI) m_np = 1'b0;
            if (m_cycle == 4 && m_src == M_RESET) m_rp = 1'b0;
            if (m_cycle == 6) begin
                m_active = 1'b0;
                m_cycle  = 0;
            end else begin
                m_cycle++;
            end
        end
        if (nmi_edge) m_np = 1'b1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) model_reset();
            else       model_step();
        end
    end

    // ---------------- compare + sequence log ----------------
    typedef struct {
        int         len;
        logic [1:0] vec;
        logic       brk;
        int         pushes;
        int         masks;
    } seq_rec_t;

    seq_rec_t log_q[$];
    int       mon_len;
    int       mon_push;
    int       mon_mask;
    logic     mon_brk;

    initial begin
        seq_rec_t r;
        mon_len = 0; mon_push = 0; mon_mask = 0; mon_brk = 1'b0;
        forever begin
            @(negedge clk);
            check("cyc.seqActive", bus.seqActive, m_active);
            check("cyc.seqStep", bus.seqStep, m_active ? m_cycle : 0);
            check("cyc.vectorSel", bus.vectorSel, m_vec);
            check("cyc.pushEnable", bus.pushEnable,
                  m_active && m_src != M_RESET && m_cycle >= 2 && m_cycle <= 4);
            check("cyc.breakFlag", bus.breakFlag, m_active && m_src == M_BRK);
            check("cyc.setInterruptMask", bus.setInterruptMask, m_active && m_cycle == 5);
            check("cyc.seqDone", bus.seqDone, m_active && m_cycle == 6);
            check("cyc.seqState", bus.seqState, m_active ? ST_SEQ : ST_IDLE);
            if (!nrst) begin
                mon_len = 0; mon_push = 0; mon_mask = 0; mon_brk = 1'b0;
            end else if (bus.seqActive) begin
                mon_len++;
                if (bus.pushEnable)       mon_push++;
                if (bus.setInterruptMask) mon_mask++;
                if (bus.breakFlag)        mon_brk = 1'b1;
                if (bus.seqDone) begin
                    r.len = mon_len; r.vec = bus.vectorSel; r.brk = mon_brk;
                    r.pushes = mon_push; r.masks = mon_mask;
                    log_q.push_back(r);
                    mon_len = 0; mon_push = 0; mon_mask = 0; mon_brk = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_boundary();
        bus.instrBoundary = 1'b1;
        tick(1);
        bus.instrBoundary = 1'b0;
    endtask

    task automatic expect_seq(input string name, input logic [1:0] vec,
                              input logic brk, input int pushes);
        seq_rec_t r;
        if (log_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no completed sequence, expected one", name);
        end else begin
            r = log_q.pop_front();
            check({name, ".len"}, r.len, 7);
            check({name, ".vec"}, r.vec, vec);
            check({name, ".brk"}, r.brk, brk);
            check({name, ".pushes"}, r.pushes, pushes);
            check({name, ".masks"}, r.masks, 1);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        finish_run();
    end

    // ---------------- directed scenarios ----------------
    initial begin
        nrst              = 1'b0;
        bus.nmi_n         = 1'b1;
        bus.irq_n         = 1'b1;
        bus.psrIrqMask    = 1'b1;
        bus.instrBoundary = 1'b0;
        bus.brkRequest    = 1'b0;
        tick(3);
        check("rst.seqActive", bus.seqActive, 0);
        check("rst.seqStep", bus.seqStep, 0);
        check("rst.vectorSel", bus.vectorSel, VEC_RESET);
        check("rst.pushEnable", bus.pushEnable, 0);
        check("rst.setInterruptMask", bus.setInterruptMask, 0);
        nrst = 1'b1;
        tick(3);
        check("rst.wait_boundary", bus.seqActive, 0);

        // reset entry at the first boundary
        pulse_boundary();
        check("reset_seq.start", bus.seqActive, 1);
        tick(8);
        expect_seq("reset_seq", VEC_RESET, 1'b0, 0);

        // IRQ taken, then masked IRQ ignored
        bus.irq_n = 1'b0;
        bus.psrIrqMask = 1'b0;
        tick(3);
        pulse_boundary();
        tick(8);
        expect_seq("irq_seq", VEC_IRQ, 1'b0, 3);
        bus.psrIrqMask = 1'b1;
        pulse_boundary();
        tick(3);
        check("irq_masked.active", bus.seqActive, 0);
        check("irq_masked.log", log_q.size(), 0);
        bus.irq_n = 1'b1;
        tick(3);

        // BRK from IDLE
        bus.brkRequest = 1'b1;
        tick(1);
        bus.brkRequest = 1'b0;
        tick(8);
        expect_seq("brk_seq", VEC_IRQ, 1'b1, 3);

        // pending NMI beats a simultaneous BRK
        bus.nmi_n = 1'b0;
        tick(4);
        bus.nmi_n = 1'b1;
        bus.brkRequest = 1'b1;
        bus.instrBoundary = 1'b1;
        tick(1);
        bus.brkRequest = 1'b0;
        bus.instrBoundary = 1'b0;
        tick(8);
        expect_seq("nmi_over_brk", VEC_NMI, 1'b0, 3);
        pulse_boundary();
        tick(3);
        check("nmi_over_brk.no_rerun", log_q.size() + bus.seqActive, 0);

        // NMI detected in step 2 hijacks the IRQ vector
        bus.irq_n = 1'b0;
        bus.psrIrqMask = 1'b0;
        tick(3);
        pulse_boundary();
        bus.irq_n = 1'b1;
        bus.nmi_n = 1'b0;
        tick(3);
        check("hijack.step3_vec", bus.vectorSel, VEC_IRQ);
        tick(1);
        check("hijack.step4_vec", bus.vectorSel, VEC_NMI);
        check("hijack.step4_brk", bus.breakFlag, 0);
        tick(4);
        expect_seq("hijack", VEC_NMI, 1'b0, 3);
        bus.nmi_n = 1'b1;
        pulse_boundary();
        tick(3);
        check("hijack.no_second", log_q.size() + bus.seqActive, 0);

        // NMI detected in step 5 waits for the next boundary
        bus.irq_n = 1'b0;
        tick(3);
        pulse_boundary();
        bus.irq_n = 1'b1;
        tick(3);
        bus.nmi_n = 1'b0;
        tick(2);
        check("late_nmi.step5_vec", bus.vectorSel, VEC_IRQ);
        check("late_nmi.step5_mask", bus.setInterruptMask, 1);
        tick(5);
        expect_seq("late_nmi.irq", VEC_IRQ, 1'b0, 3);
        bus.nmi_n = 1'b1;
        check("late_nmi.idle", bus.seqActive, 0);
        pulse_boundary();
        tick(8);
        expect_seq("late_nmi.nmi", VEC_NMI, 1'b0, 3);
        bus.psrIrqMask = 1'b1;

        // reset asserted in step 3 aborts and re-arms the reset entry
        bus.brkRequest = 1'b1;
        tick(1);
        bus.brkRequest = 1'b0;
        tick(3);
        check("abort.pre_step", bus.seqStep, 3);
        check("abort.pre_push", bus.pushEnable, 1);
        nrst = 1'b0;
        #1;
        check("abort.seqActive", bus.seqActive, 0);
        check("abort.seqStep", bus.seqStep, 0);
        check("abort.vectorSel", bus.vectorSel, VEC_RESET);
        check("abort.pushEnable", bus.pushEnable, 0);
        check("abort.breakFlag", bus.breakFlag, 0);
        tick(2);
        nrst = 1'b1;
        tick(3);
        check("abort.no_record", log_q.size(), 0);
        pulse_boundary();
        tick(8);
        expect_seq("abort.reset_seq", VEC_RESET, 1'b0, 0);

        tick(2);
        finish_run();
    end

endmodule
